// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and widths for the data-memory access controller.
package dmem_pkg;

  localparam int unsigned DMEM_LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } dmem_owner_t;

  // Round-robin helper: the requester that did not win last time.
  function automatic dmem_owner_t otherOwner(input dmem_owner_t o);
    return (o == OWN_CPU) ? OWN_DBG : OWN_CPU;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_arb.sv
// dmem_rr_arbiter: two-requester round-robin arbiter (CPU vs debug port).
module dmem_rr_arbiter
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpuReq,
  input  logic        dbgReq,
  input  logic        grantEn,
  output logic        grantValid_c,
  output dmem_owner_t grantOwner_c
);

  dmem_owner_t lastOwner;

  // Grant selection: single requester wins, a tie goes to whoever did not win last.
  always_comb begin
    grantValid_c = grantEn & (cpuReq | dbgReq);
    grantOwner_c = OWN_CPU;
    if (cpuReq && dbgReq) begin
      grantOwner_c = otherOwner(lastOwner);
    end else if (dbgReq) begin
      grantOwner_c = OWN_DBG;
    end
  end

  // Remember the latest winner; reset to DBG so the first tie favours the CPU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastOwner <= OWN_DBG;
    end else if (grantValid_c) begin
      lastOwner <= grantOwner_c;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences CPU and debug accesses to the single-port data memory,
// holding the port for LATENCY cycles per access and stalling the pipeline meanwhile.
// Optional build macro DMEM_PERF_CNT_EN adds perf_stall_cnt, a saturating count of
// stalled cycles.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             stall_m,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [WIDTH-1:0] dbg_addr,
  input  logic [WIDTH-1:0] dbg_wdata,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic             dbg_done,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_wen,
  input  logic [WIDTH-1:0] mem_rdata
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cnt
`endif
);

  localparam logic [1:0] StIdle   = IDLE;
  localparam logic [1:0] StAccess = ACCESS;
  localparam logic [1:0] StDone   = DONE;

  localparam logic [DMEM_LAT_W-1:0] LatInit = DMEM_LAT_W'(LATENCY - 1);

  logic [1:0]            state;
  logic [1:0]            nextState;
  dmem_owner_t           owner;
  logic [DMEM_LAT_W-1:0] latCnt;
  logic                  reqWe;
  logic                  grantValid_c;
  dmem_owner_t           grantOwner_c;
  logic                  inAccess_c;
  logic                  latZero_c;
  logic                  inDone_c;

  assign inAccess_c = (state == StAccess);
  assign inDone_c   = (state == StDone);
  assign latZero_c  = (latCnt == '0);

  dmem_rr_arbiter u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpuReq       (cpu_req),
    .dbgReq       (dbg_req),
    .grantEn      (state == StIdle),
    .grantValid_c (grantValid_c),
    .grantOwner_c (grantOwner_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
    end else begin
      state <= nextState;
    end
  end

  // Next state: IDLE -> ACCESS on grant, ACCESS -> DONE at lat_cnt 0, DONE -> IDLE.
  always_comb begin
    nextState = state;
    case (state)
      StIdle:   if (grantValid_c) nextState = StAccess;
      StAccess: if (latZero_c)    nextState = StDone;
      StDone:   nextState = StIdle;
      default:  nextState = StIdle;
    endcase
  end

  // Request capture at grant, latency countdown, and load-data capture on the last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_CPU;
      latCnt    <= '0;
      reqWe     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      if (grantValid_c) begin
        owner  <= grantOwner_c;
        latCnt <= LatInit;
        if (grantOwner_c == OWN_CPU) begin
          reqWe     <= cpu_we;
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
        end else begin
          reqWe     <= dbg_we;
          mem_addr  <= dbg_addr;
          mem_wdata <= dbg_wdata;
        end
      end else if (inAccess_c && !latZero_c) begin
        latCnt <= latCnt - DMEM_LAT_W'(1);
      end
      if (inAccess_c && latZero_c && !reqWe) begin
        if (owner == OWN_CPU) begin
          cpu_rdata <= mem_rdata;
        end else begin
          dbg_rdata <= mem_rdata;
        end
      end
    end
  end

  // Write strobe only on the final access cycle; stall released in the CPU's DONE cycle.
  assign mem_wen  = inAccess_c & latZero_c & reqWe;
  assign stall_m  = cpu_req & ~(inDone_c & (owner == OWN_CPU));
  assign dbg_done = inDone_c & (owner == OWN_DBG);

`ifdef DMEM_PERF_CNT_EN
  // Saturating count of cycles with the pipeline stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
    end else if (stall_m && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed scoreboard bench for dmem_access_ctrl.
// With DMEM_PERF_CNT_EN defined, a second LATENCY=1 instance exercises the stall counter.
module tb_dmem_access_ctrl;

  localparam int unsigned LAT = 2;
  localparam logic [7:0] TagCpu = 8'h43;
  localparam logic [7:0] TagDbg = 8'h44;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        stall_m, dbg_done, mem_wen;

  logic [31:0] mem    [0:63] = '{default: '0};
  logic [31:0] refMem [0:63] = '{default: '0};

  logic [63:0] wrQ [$];
  logic [31:0] cpuQ [$];
  logic [31:0] dbgQ [$];
  logic [7:0]  ordQ [$];

  int nCmp = 0;
  int nErr = 0;
  int cyc = 0;
  int wenCnt = 0;
  int lastWenCyc = 0;
  int cpuDoneCnt = 0;
  int dbgDoneCnt = 0;
  logic [31:0] lastCpuRd = '0;
  logic [31:0] lastDbgRd = '0;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic        p_req, p_stall, p_dbg_done, p_wen;
  logic [31:0] p_addr, p_rdata, p_dbg_rdata, p_mem_addr, p_mem_wdata, p_mem_rdata, p_perf;
  logic        p_zero1;
  logic [31:0] p_zero32;
`endif

  dmem_access_ctrl #(.WIDTH(32), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall_m   (stall_m),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_done  (dbg_done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata)
`ifdef DMEM_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

`ifdef DMEM_PERF_CNT_EN
  assign p_mem_rdata = p_mem_addr ^ 32'h0F0F_0000;

  dmem_access_ctrl #(.WIDTH(32), .LATENCY(1)) u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req        (p_req),
    .cpu_we         (p_zero1),
    .cpu_addr       (p_addr),
    .cpu_wdata      (p_zero32),
    .cpu_rdata      (p_rdata),
    .stall_m        (p_stall),
    .dbg_req        (p_zero1),
    .dbg_we         (p_zero1),
    .dbg_addr       (p_zero32),
    .dbg_wdata      (p_zero32),
    .dbg_rdata      (p_dbg_rdata),
    .dbg_done       (p_dbg_done),
    .mem_addr       (p_mem_addr),
    .mem_wdata      (p_mem_wdata),
    .mem_wen        (p_wen),
    .mem_rdata      (p_mem_rdata),
    .perf_stall_cnt (p_perf)
  );
`endif

  // Clock and a hard time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Data memory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic popOrder(input logic [7:0] tag);
    if (ordQ.size() == 0) chk("orderQueue", 32'(ordQ.size()), 32'd1);
    else chk("grantOrder", 32'(ordQ.pop_front()), 32'(tag));
  endtask

  // Scoreboard monitor, called once per cycle at the falling edge.
  task automatic sample();
    logic [63:0] w;
    if (mem_wen === 1'b1) begin
      wenCnt++;
      lastWenCyc = cyc;
      if (wrQ.size() == 0) chk("wrQueue", 32'(wrQ.size()), 32'd1);
      else begin
        w = wrQ.pop_front();
        chk("wrAddr", mem_addr, w[63:32]);
        chk("wrData", mem_wdata, w[31:0]);
      end
    end
    if (dbg_done === 1'b1) begin
      dbgDoneCnt++;
      if (dbgQ.size() == 0) chk("dbgQueue", 32'(dbgQ.size()), 32'd1);
      else chk("dbgRdata", dbg_rdata, dbgQ.pop_front());
      popOrder(TagDbg);
    end
    if (cpu_req === 1'b1 && stall_m === 1'b0) begin
      cpuDoneCnt++;
      if (cpuQ.size() == 0) chk("cpuQueue", 32'(cpuQ.size()), 32'd1);
      else chk("cpuRdata", cpu_rdata, cpuQ.pop_front());
      popOrder(TagCpu);
    end
    if (cpu_req === 1'b0) chk("stallNoReq", 32'(stall_m), 32'd0);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic waitCpu(input int maxCyc);
    int c0;
    c0 = cpuDoneCnt;
    for (int i = 0; i < maxCyc && cpuDoneCnt == c0; i++) tick();
    if (cpuDoneCnt == c0) chk("cpuTimeout", 32'(cpuDoneCnt - c0), 32'd1);
  endtask

  task automatic waitDbg(input int maxCyc);
    int d0;
    d0 = dbgDoneCnt;
    for (int i = 0; i < maxCyc && dbgDoneCnt == d0; i++) tick();
    if (dbgDoneCnt == d0) chk("dbgTimeout", 32'(dbgDoneCnt - d0), 32'd1);
  endtask

  task automatic cpuOp(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int k, w0;
    if (we) begin
      wrQ.push_back({addr, wdata});
      refMem[addr[7:2]] = wdata;
    end else begin
      lastCpuRd = refMem[addr[7:2]];
    end
    cpuQ.push_back(lastCpuRd);
    ordQ.push_back(TagCpu);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    k = cyc; w0 = wenCnt;
    #1 chk("stallAtGrant", 32'(stall_m), 32'd1);
    waitCpu(16);
    chk("cpuDoneCycle", 32'(cyc - k), 32'(LAT + 1));
    chk("cpuWenCount", 32'(wenCnt - w0), 32'(we));
    if (we) chk("cpuWenCycle", 32'(lastWenCyc - k), 32'(LAT));
    cpu_req = 1'b0;
  endtask

  task automatic dbgOp(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int k;
    if (we) begin
      wrQ.push_back({addr, wdata});
      refMem[addr[7:2]] = wdata;
    end else begin
      lastDbgRd = refMem[addr[7:2]];
    end
    dbgQ.push_back(lastDbgRd);
    ordQ.push_back(TagDbg);
    dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    k = cyc;
    waitDbg(16);
    chk("dbgDoneCycle", 32'(cyc - k), 32'(LAT + 1));
    dbg_req = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick(); tick();
    chk("queuesEmpty", 32'(wrQ.size() + cpuQ.size() + dbgQ.size() + ordQ.size()), 32'd0);
    rst_n = 1'b1;
    lastCpuRd = '0; lastDbgRd = '0;
  endtask

  initial begin
    int k, w0, c0, d0, cpuCyc, dbgCyc;
    logic switched;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
`ifdef DMEM_PERF_CNT_EN
    p_req = 1'b0; p_addr = '0; p_zero1 = 1'b0; p_zero32 = '0;
`endif

    // Reset state.
    tick(); tick(); tick();
    chk("rstStall", 32'(stall_m), 32'd0);
    chk("rstWen", 32'(mem_wen), 32'd0);
    chk("rstDbgDone", 32'(dbg_done), 32'd0);
    chk("rstCpuRdata", cpu_rdata, 32'd0);
    chk("rstDbgRdata", dbg_rdata, 32'd0);
    chk("rstMemAddr", mem_addr, 32'd0);
    chk("rstMemWdata", mem_wdata, 32'd0);
`ifdef DMEM_PERF_CNT_EN
    chk("rstPerf", perf_stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // CPU store then load of the same word.
    cpuOp(1'b1, 32'h10, 32'hDEADBEEF);
    tick(); tick();
    chk("addrHold", mem_addr, 32'h10);
    chk("wdataHold", mem_wdata, 32'hDEADBEEF);
    chk("wenIdle", 32'(mem_wen), 32'd0);
    cpuOp(1'b0, 32'h10, 32'h0);
    tick();

    // Simultaneous requests from reset: CPU first, DBG after; CPU drops its request.
    doReset();
    lastCpuRd = refMem[4];
    cpuQ.push_back(lastCpuRd);
    ordQ.push_back(TagCpu);
    ordQ.push_back(TagDbg);
    wrQ.push_back({32'h20, 32'hCAFEF00D});
    refMem[8] = 32'hCAFEF00D;
    dbgQ.push_back(lastDbgRd);
    cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0; cpu_req = 1'b1;
    dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'hCAFEF00D; dbg_req = 1'b1;
    c0 = cpuDoneCnt; d0 = dbgDoneCnt; cpuCyc = 0; dbgCyc = 0;
    for (int i = 0; i < 30 && dbgDoneCnt == d0; i++) begin
      tick();
      if (cpuDoneCnt != c0 && cpu_req) begin
        cpuCyc = cyc;
        cpu_req = 1'b0;
      end
    end
    dbgCyc = cyc;
    dbg_req = 1'b0;
    chk("tieCpuDone", 32'(cpuDoneCnt - c0), 32'd1);
    chk("tieDbgDone", 32'(dbgDoneCnt - d0), 32'd1);
    chk("dbgAfterCpu", 32'(dbgCyc - cpuCyc), 32'(LAT + 2));
    tick();

    // Debug load of the word it just wrote.
    dbgOp(1'b0, 32'h20, 32'h0);
    tick();

    // Back-to-back contention over three accesses: CPU, DBG, CPU.
    wrQ.push_back({32'h30, 32'h11111111});
    wrQ.push_back({32'h40, 32'h22222222});
    wrQ.push_back({32'h34, 32'h33333333});
    refMem[12] = 32'h11111111; refMem[16] = 32'h22222222; refMem[13] = 32'h33333333;
    cpuQ.push_back(lastCpuRd); cpuQ.push_back(lastCpuRd);
    dbgQ.push_back(lastDbgRd);
    ordQ.push_back(TagCpu); ordQ.push_back(TagDbg); ordQ.push_back(TagCpu);
    cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h11111111; cpu_req = 1'b1;
    dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h22222222; dbg_req = 1'b1;
    c0 = cpuDoneCnt; d0 = dbgDoneCnt; switched = 1'b0;
    for (int i = 0; i < 40 && (cpuDoneCnt - c0) + (dbgDoneCnt - d0) < 3; i++) begin
      tick();
      if (cpuDoneCnt - c0 == 1 && !switched) begin
        cpu_addr = 32'h34; cpu_wdata = 32'h33333333;
        switched = 1'b1;
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("rrCpuCount", 32'(cpuDoneCnt - c0), 32'd2);
    chk("rrDbgCount", 32'(dbgDoneCnt - d0), 32'd1);
    chk("rrWrDrained", 32'(wrQ.size()), 32'd0);
    tick();
    chk("memWord30", mem[12], 32'h11111111);
    chk("memWord34", mem[13], 32'h33333333);
    chk("memWord40", mem[16], 32'h22222222);

    // Reset in the middle of a CPU store; the store must complete exactly once afterwards.
    lastCpuRd = '0;
    cpuQ.push_back(lastCpuRd);
    ordQ.push_back(TagCpu);
    wrQ.push_back({32'h50, 32'h55555555});
    refMem[20] = 32'h55555555;
    cpu_we = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'h55555555; cpu_req = 1'b1;
    w0 = wenCnt;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midRstWen", 32'(mem_wen), 32'd0);
    chk("midRstAddr", mem_addr, 32'd0);
    chk("midRstWdata", mem_wdata, 32'd0);
    chk("midRstCpuRdata", cpu_rdata, 32'd0);
    chk("midRstDbgRdata", dbg_rdata, 32'd0);
    chk("midRstDbgDone", 32'(dbg_done), 32'd0);
    tick(); tick();
    chk("memUntouched", mem[20], 32'd0);
    chk("noWenInReset", 32'(wenCnt - w0), 32'd0);
    rst_n = 1'b1;
    lastDbgRd = '0;
    k = cyc;
    waitCpu(16);
    chk("rearbDoneCycle", 32'(cyc - k), 32'(LAT + 1));
    cpu_req = 1'b0;
    tick();
    chk("storeOnce", 32'(wenCnt - w0), 32'd1);
    chk("memWord50", mem[20], 32'h55555555);

`ifdef DMEM_PERF_CNT_EN
    // Four back-to-back CPU loads at LATENCY=1 stall for two cycles each.
    p_addr = 32'h4; p_req = 1'b1;
    c0 = 0;
    for (int i = 0; i < 40 && c0 < 4; i++) begin
      tick();
      if (p_stall === 1'b0) begin
        c0++;
        chk("perfRdata", p_rdata, 32'h0F0F_0004);
      end
    end
    p_req = 1'b0;
    chk("perfLoads", 32'(c0), 32'd4);
    tick(); tick();
    chk("perfStallCnt", p_perf, 32'd8);
`endif

    chk("leftover", 32'(wrQ.size() + cpuQ.size() + dbgQ.size() + ordQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
